// File: rtl/psg_pkg.sv
// psg_pkg: shared types, LFSR tap table and amplitude helper for the PSG voice
package psg_pkg;
  typedef enum logic [1:0] {SQ50, P25, P12, NOISE} mode_t;
  typedef enum logic [1:0] {IDLE, SUSTAIN, DECAY} env_state_t;
  // Tap masks use polynomial-exponent numbering: bit w-1 is x^w.
  function automatic logic [31:0] lfsr_taps(input int w);
    return w == 7 ? 32'h60 : w == 9 ? 32'h110 : w == 15 ? 32'h6000 : w == 16 ? 32'hB400 : 32'h0;
  endfunction
  function automatic logic [31:0] amp_of(input logic [7:0] level);
    return (32'd1 << level) - 32'd1;
  endfunction
endpackage

// File: rtl/tt_um_accelshark_psg_voice_v2_if.sv
// tt_um_accelshark_psg_voice_v2_if: control inputs and stereo outputs of one PSG voice
// master drives ena/key_on/mode/octave/pitch/volume/env_decay/pan and reads mix_l/mix_r/env_active;
// slave is the voice side.
interface tt_um_accelshark_psg_voice_v2_if #(parameter int PITCH_W = 10, VOL_W = 4, OUT_W = 16);
  logic ena, key_on, env_active;
  logic [1:0] mode, octave, pan;
  logic [PITCH_W-1:0] pitch;
  logic [VOL_W-1:0] volume;
  logic [3:0] env_decay;
  logic [OUT_W-1:0] mix_l, mix_r;
  modport master (output ena, key_on, mode, octave, pitch, volume, env_decay, pan,
                  input mix_l, mix_r, env_active);
  modport slave (input ena, key_on, mode, octave, pitch, volume, env_decay, pan,
                 output mix_l, mix_r, env_active);
endinterface

// File: rtl/tt_um_accelshark_psg_envelope.sv
// tt_um_accelshark_psg_envelope: decay envelope FSM producing the voice level
// clk, rst_n (async, active-low), ena (freeze), base_tick, key_on, volume, env_decay in;
// level, env_active out.
module tt_um_accelshark_psg_envelope
  import psg_pkg::*;
#(
  parameter int VOL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             base_tick,
  input  logic             key_on,
  input  logic [VOL_W-1:0] volume,
  input  logic [3:0]       env_decay,
  output logic [VOL_W-1:0] level,
  output logic             env_active
);
  env_state_t state;
  logic [3:0] decay;
  logic [7:0] cnt;
  assign env_active = state != IDLE;
  // Decay step lasts 16*decay base ticks, so the terminal count is {decay-1, 4'hF}.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      decay <= '0;
      cnt   <= '0;
      level <= '0;
    end else if (ena) begin
      if (key_on) begin
        level <= volume;
        cnt   <= '0;
        decay <= env_decay;
        state <= volume == '0 ? IDLE : env_decay == 4'd0 ? SUSTAIN : DECAY;
      end else if (state == SUSTAIN) begin
        level <= volume;
      end else if (state == DECAY && base_tick) begin
        if (cnt == {decay - 4'd1, 4'hF}) begin
          cnt   <= '0;
          level <= level - 1'b1;
          if (level == VOL_W'(1)) state <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
endmodule

// File: rtl/tt_um_accelshark_psg_voice_v2.sv
// tt_um_accelshark_psg_voice_v2: clock-enable PSG voice with tone/noise, decay envelope and panned output
// clk, rst_n (async, active-low); bus (slave) carries the voice controls in and mix_l/mix_r/env_active out.
module tt_um_accelshark_psg_voice_v2
  import psg_pkg::*;
#(
  parameter int PREDIV  = 5,
  parameter int PITCH_W = 10,
  parameter int VOL_W   = 4,
  parameter int OUT_W   = 16,
  parameter int LFSR_W  = 15
) (
  input logic clk,
  input logic rst_n,
  tt_um_accelshark_psg_voice_v2_if.slave bus
);
  localparam int PW = PREDIV + 3;
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));
  logic [PW-1:0] pre;
  logic [PITCH_W-1:0] cnt;
  logic [2:0] phase;
  logic [LFSR_W-1:0] lfsr, taps_rev;
  logic [VOL_W-1:0] level;
  logic [OUT_W-1:0] amp, sample;
  logic base_tick, pitch_tick, wave;
  mode_t wmode;
  // The tap table counts from the MSB end; mirror it because the register shifts toward bit0.
  assign taps_rev = {<<{TAPS}};
  assign base_tick = &pre[PREDIV-1:0];
  assign pitch_tick = &(pre | ~({PW{1'b1}} >> bus.octave));
  assign wmode = mode_t'(bus.mode);
  assign wave = wmode == SQ50 ? phase[2] : wmode == P25 ? phase >= 3'd6 : wmode == P12 ? &phase : lfsr[0];
  assign amp = OUT_W'(amp_of(8'(level)));
  assign sample = wave ? amp : -amp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre       <= '0;
      cnt       <= '0;
      phase     <= '0;
      lfsr      <= LFSR_W'(1);
      bus.mix_l <= '0;
      bus.mix_r <= '0;
    end else begin
      bus.mix_l <= bus.ena && bus.pan[0] ? sample : '0;
      bus.mix_r <= bus.ena && bus.pan[1] ? sample : '0;
      if (bus.ena) begin
        pre <= pre + 1'b1;
        if (pitch_tick) begin
          if (cnt == '0) begin
            cnt   <= bus.pitch;
            phase <= phase + 1'b1;
            lfsr  <= {^(lfsr & taps_rev), lfsr[LFSR_W-1:1]};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      end
    end
  tt_um_accelshark_psg_envelope #(.VOL_W(VOL_W)) u_env (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (bus.ena),
    .base_tick  (base_tick),
    .key_on     (bus.key_on),
    .volume     (bus.volume),
    .env_decay  (bus.env_decay),
    .level      (level),
    .env_active (bus.env_active)
  );
endmodule

// File: tb/tb_tt_um_accelshark_psg_voice_v2.sv
// tb_tt_um_accelshark_psg_voice_v2: random and directed stimulus against a behavioural voice model
module tb_tt_um_accelshark_psg_voice_v2;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  tt_um_accelshark_psg_voice_v2_if bus ();
  tt_um_accelshark_psg_voice_v2 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_checks = 0, n_errors = 0;
  int t, wt, reloads, lf, est, lvl, dcnt, dlen;
  logic [15:0] el, er;
  int hi, lo, n;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int mag(input logic [15:0] v);
    return $signed(v) < 0 ? -int'($signed(v)) : int'($signed(v));
  endfunction
  task automatic model_reset();
    t = 0; wt = 0; reloads = 0; lf = 1; est = 0; lvl = 0; dcnt = 0; dlen = 0; el = 0; er = 0;
  endtask
  // Advances the model across the coming clock edge using the inputs now on the bus.
  task automatic model_step();
    int ph, amp;
    bit wave, base, ptk;
    logic [15:0] smp;
    ph = reloads % 8;
    case (bus.mode)
      2'd0: wave = ph >= 4;
      2'd1: wave = ph >= 6;
      2'd2: wave = ph == 7;
      default: wave = lf[0];
    endcase
    amp = (1 << lvl) - 1;
    smp = wave ? 16'(amp) : 16'(-amp);
    el = (bus.ena && bus.pan[0]) ? smp : 16'd0;
    er = (bus.ena && bus.pan[1]) ? smp : 16'd0;
    if (!bus.ena) return;
    base = ((t + 1) % 32) == 0;
    ptk = ((t + 1) % (32 << (3 - bus.octave))) == 0;
    t++;
    if (ptk) begin
      if (wt == 0) begin
        wt = bus.pitch;
        reloads++;
        // x^15+x^14+1 shifting toward bit0: feedback from the two oldest bits into bit14
        lf = (lf >> 1) | (((lf ^ (lf >> 1)) & 1) << 14);
      end else wt--;
    end
    if (bus.key_on) begin
      lvl = bus.volume; dcnt = 0; dlen = 16 * bus.env_decay;
      est = bus.volume == 0 ? 0 : bus.env_decay == 0 ? 1 : 2;
    end else if (est == 1) lvl = bus.volume;
    else if (est == 2 && base) begin
      dcnt++;
      if (dcnt == dlen) begin
        dcnt = 0; lvl--;
        if (lvl == 0) est = 0;
      end
    end
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("mix_l", bus.mix_l, el);
    check("mix_r", bus.mix_r, er);
    check("env_active", bus.env_active, est != 0);
    bus.key_on = 0;
  endtask
  task automatic run(input int k);
    repeat (k) cyc();
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_mix_l", bus.mix_l, 0);
    check("rst_mix_r", bus.mix_r, 0);
    check("rst_env_active", bus.env_active, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic duty(input int win);
    hi = 0; lo = 0;
    repeat (win) begin
      cyc();
      if (bus.mix_l == 16'h7FFF) hi++;
      if (bus.mix_l == 16'h8001) lo++;
    end
  endtask
  initial begin
    bus.ena = 1; bus.key_on = 0; bus.mode = 0; bus.octave = 3; bus.pitch = 1;
    bus.volume = 4'hF; bus.env_decay = 0; bus.pan = 3;
    model_reset();
    repeat (2) @(negedge clk);
    check("init_mix_l", bus.mix_l, 0);
    check("init_mix_r", bus.mix_r, 0);
    check("init_env_active", bus.env_active, 0);
    rst_n = 1;
    bus.key_on = 1;
    run(100);
    duty(512);
    check("sq50_high", hi, 256);
    check("sq50_low", lo, 256);
    do_reset();
    bus.mode = 2; bus.key_on = 1;
    run(10);
    duty(512);
    check("p12_high", hi, 64);
    check("p12_low", lo, 448);
    bus.octave = 0;
    run(600);
    duty(4096);
    check("p12_oct0_high", hi, 512);
    check("p12_oct0_low", lo, 3584);
    bus.octave = 3; bus.mode = 0; bus.volume = 4; bus.env_decay = 1;
    while ((t + 1) % 32 != 0) cyc();
    bus.key_on = 1;
    cyc();
    n = 0;
    while (bus.env_active && n < 3000) begin
      cyc();
      n++;
    end
    check("decay_len", n, 2048);
    bus.key_on = 1;
    run(1100);
    check("pre_retrig_amp", mag(bus.mix_l), 3);
    bus.key_on = 1;
    run(2);
    check("retrig_amp", mag(bus.mix_l), 15);
    bus.mode = 3; bus.pitch = 0; bus.env_decay = 0; bus.volume = 4'hF;
    do_reset();
    bus.key_on = 1;
    run(3000);
    bus.mode = 0; bus.pitch = 3; bus.volume = 8; bus.env_decay = 2; bus.pan = 1; bus.key_on = 1;
    run(700);
    bus.ena = 0;
    run(1000);
    bus.ena = 1;
    run(1500);
    repeat (40) begin
      bus.mode = 2'($urandom_range(0, 3));
      bus.octave = 2'($urandom_range(0, 3));
      bus.pitch = 10'($urandom_range(0, 15));
      bus.volume = 4'($urandom_range(0, 15));
      bus.env_decay = 4'($urandom_range(0, 3));
      bus.pan = 2'($urandom_range(0, 3));
      bus.key_on = 1'($urandom_range(0, 1));
      repeat ($urandom_range(100, 400)) begin
        bus.ena = $urandom_range(0, 15) != 0;
        if ($urandom_range(0, 299) == 0) bus.key_on = 1;
        cyc();
      end
    end
    bus.ena = 1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
